// File: rtl/clkdiv_sel_ctrl_if.sv
// Ratio-change request channel and switch status for clkdiv_sel_ctrl.
// The master issues requests. The slave is the controller.
interface clkdiv_sel_ctrl_if #(
    parameter int unsigned SEL_W = 2
) ();
    logic             sel_req_valid;
    logic [SEL_W-1:0] sel_req;
    logic             sel_req_ready;
    logic [SEL_W-1:0] cur_sel;
    logic             switch_busy;
    logic             switch_done;
    logic             sel_err;

    modport master (
        output sel_req_valid,
        output sel_req,
        input  sel_req_ready,
        input  cur_sel,
        input  switch_busy,
        input  switch_done,
        input  sel_err
    );

    modport slave (
        input  sel_req_valid,
        input  sel_req,
        output sel_req_ready,
        output cur_sel,
        output switch_busy,
        output switch_done,
        output sel_err
    );
endinterface

// File: rtl/clkdiv_sel_ctrl.sv
// Runtime divide-ratio controller. A free-running counter provides taps for the divided output.
// Tap changes are deferred to the counter wrap so div_out never glitches.
module clkdiv_sel_ctrl #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned DEFAULT_SEL = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    clkdiv_sel_ctrl_if.slave sel_if,
    output logic             o_div_out,
    output logic             o_div_tick
);

    localparam logic             StIdle = 1'b0;
    localparam logic             StPend = 1'b1;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam int unsigned      PadW   = 1 << SEL_W;

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_div_out;
    logic             r_div_tick;
    logic             r_done;
    logic             r_err;

    logic             w_xfer;
    logic [31:0]      w_req_ext;
    logic             w_req_bad;
    logic             w_req_same;
    logic             w_wrap;
    logic             w_switch;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [PadW-1:0]  w_cnt_pad;
    logic             w_div_nxt;

    always_comb begin
        w_xfer     = sel_if.sel_req_valid && (r_state == StIdle);
        w_req_ext  = 32'(sel_if.sel_req);
        w_req_bad  = (w_req_ext >= CNT_W);
        w_req_same = (sel_if.sel_req == r_cur_sel);
        w_wrap     = i_enable && (r_cnt == CntMax);
        w_switch   = (r_state == StPend) && w_wrap;
        w_cnt_nxt  = i_enable ? (r_cnt + CNT_W'(1)) : r_cnt;
        w_sel_nxt  = w_switch ? r_pend_sel : r_cur_sel;
        // Zero-pad so any selector value indexes a real bit.
        w_cnt_pad  = PadW'(w_cnt_nxt);
        w_div_nxt  = w_cnt_pad[w_sel_nxt];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_cur_sel  <= SEL_W'(DEFAULT_SEL);
            r_pend_sel <= '0;
            r_div_out  <= 1'b0;
            r_div_tick <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_cur_sel <= w_sel_nxt;
            r_div_out <= w_div_nxt;
            if (i_enable) begin
                r_div_tick <= w_div_nxt & ~r_div_out;
            end
            r_err  <= w_xfer & w_req_bad;
            r_done <= (w_xfer & ~w_req_bad & w_req_same) | w_switch;
            if (r_state == StIdle) begin
                if (w_xfer && !w_req_bad && !w_req_same) begin
                    r_state    <= StPend;
                    r_pend_sel <= sel_if.sel_req;
                end
            end else if (w_wrap) begin
                r_state <= StIdle;
            end
        end
    end

    assign sel_if.sel_req_ready = (r_state == StIdle);
    assign sel_if.cur_sel       = r_cur_sel;
    assign sel_if.switch_busy   = (r_state == StPend);
    assign sel_if.switch_done   = r_done;
    assign sel_if.sel_err       = r_err;
    assign o_div_out            = r_div_out;
    assign o_div_tick           = r_div_tick;

endmodule

// File: tb/tb_clkdiv_sel_ctrl.sv
// Directed bench for clkdiv_sel_ctrl: reset, deferred switch, same-tap request,
// switch held off by enable, reset while pending, and a rejected out-of-range request.
module tb_clkdiv_sel_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en_a = 1'b1;
    logic en_b = 1'b1;
    logic div_a, tick_a, div_b, tick_b;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   exp_sel = 0;
    logic exp_div = 1'b0;
    logic exp_tick = 1'b0;
    int   hi_cnt, tick_cnt;
    logic b_prev;

    clkdiv_sel_ctrl_if #(.SEL_W(2)) if_a ();
    clkdiv_sel_ctrl_if #(.SEL_W(2)) if_b ();

    clkdiv_sel_ctrl #(.CNT_W(4), .SEL_W(2), .DEFAULT_SEL(0)) u_dut_a (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_enable  (en_a),
        .sel_if    (if_a.slave),
        .o_div_out (div_a),
        .o_div_tick(tick_a)
    );

    clkdiv_sel_ctrl #(.CNT_W(3), .SEL_W(2), .DEFAULT_SEL(0)) u_dut_b (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_enable  (en_b),
        .sel_if    (if_b.slave),
        .o_div_out (div_b),
        .o_div_tick(tick_b)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge on DUT A, then advance the expected counter/tap state.
    task automatic adv();
        logic nb;
        @(posedge clk);
        #1;
        if (en_a) begin
            exp_cnt  = (exp_cnt + 1) % 16;
            nb       = ((exp_cnt >> exp_sel) & 1) != 0;
            exp_tick = nb && !exp_div;
            exp_div  = nb;
        end
    endtask

    task automatic chk_div();
        chk("div_a", {31'd0, div_a}, {31'd0, exp_div});
        chk("tick_a", {31'd0, tick_a}, {31'd0, exp_tick});
    endtask

    task automatic chk_status(input string tag, input logic busy, input logic done,
                              input logic rdy, input int sel);
        chk({tag, "_busy"}, {31'd0, if_a.switch_busy}, {31'd0, busy});
        chk({tag, "_done"}, {31'd0, if_a.switch_done}, {31'd0, done});
        chk({tag, "_ready"}, {31'd0, if_a.sel_req_ready}, {31'd0, rdy});
        chk({tag, "_cur_sel"}, {30'd0, if_a.cur_sel}, sel);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b1, 0);
        chk({tag, "_div"}, {31'd0, div_a}, 0);
        chk({tag, "_tick"}, {31'd0, tick_a}, 0);
        chk({tag, "_err"}, {31'd0, if_a.sel_err}, 0);
    endtask

    initial begin
        if_a.sel_req_valid = 1'b0;
        if_a.sel_req       = '0;
        if_b.sel_req_valid = 1'b0;
        if_b.sel_req       = '0;

        // Reset and divide-by-2 out of reset
        #1 rst_n = 1'b0;
        #14;
        chk_reset_vals("rst");
        #5 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            adv();
            chk_div();
            chk("tap0_div", {31'd0, div_a}, i % 2 == 0 ? 1 : 0);
            chk_status("tap0", 1'b0, 1'b0, 1'b1, 0);
        end

        // Move to cnt=5, request tap 3
        while (exp_cnt != 5) begin
            adv();
            chk_div();
        end
        if_a.sel_req_valid = 1'b1;
        if_a.sel_req       = 2'd3;
        adv();
        if_a.sel_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_status("pend3", 1'b1, 1'b0, 1'b0, 0);
            chk_div();
            if (i < 9) adv();
        end
        exp_sel = 3;
        adv();
        chk_status("sw3", 1'b0, 1'b1, 1'b1, 3);
        chk("sw3_div", {31'd0, div_a}, 0);
        chk("sw3_tick", {31'd0, tick_a}, 0);
        hi_cnt   = 0;
        tick_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            adv();
            chk_div();
            if (i == 0) chk("sw3_done_clr", {31'd0, if_a.switch_done}, 0);
            hi_cnt   += int'(div_a);
            tick_cnt += int'(tick_a);
        end
        chk("tap3_high_cycles", hi_cnt, 8);
        chk("tap3_ticks", tick_cnt, 1);

        // Request for the tap already in use
        if_a.sel_req_valid = 1'b1;
        if_a.sel_req       = 2'd3;
        adv();
        if_a.sel_req_valid = 1'b0;
        chk_status("same", 1'b0, 1'b1, 1'b1, 3);
        chk_div();
        adv();
        chk_status("same2", 1'b0, 1'b0, 1'b1, 3);
        chk_div();

        // Pending switch to tap 1 frozen by enable=0 at cnt=9
        while (exp_cnt != 8) begin
            adv();
            chk_div();
        end
        if_a.sel_req_valid = 1'b1;
        if_a.sel_req       = 2'd1;
        adv();
        if_a.sel_req_valid = 1'b0;
        chk_status("p1", 1'b1, 1'b0, 1'b0, 3);
        chk("p1_div", {31'd0, div_a}, 1);
        en_a = 1'b0;
        for (int i = 0; i < 50; i++) begin
            adv();
            chk_status("hold", 1'b1, 1'b0, 1'b0, 3);
            chk("hold_div", {31'd0, div_a}, 1);
        end
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adv();
            chk_status("run1", 1'b1, 1'b0, 1'b0, 3);
            chk_div();
        end
        exp_sel = 1;
        adv();
        chk_status("sw1", 1'b0, 1'b1, 1'b1, 1);
        chk("sw1_div", {31'd0, div_a}, 0);
        chk("sw1_tick", {31'd0, tick_a}, 0);
        for (int i = 0; i < 8; i++) begin
            adv();
            chk_div();
        end

        // Reset while a switch to tap 2 is pending
        if_a.sel_req_valid = 1'b1;
        if_a.sel_req       = 2'd2;
        adv();
        if_a.sel_req_valid = 1'b0;
        chk_status("p2", 1'b1, 1'b0, 1'b0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        exp_cnt  = 0;
        exp_sel  = 0;
        exp_div  = 1'b0;
        exp_tick = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            adv();
            chk_status("post_rst", 1'b0, 1'b0, 1'b1, 0);
            chk_div();
        end

        // CNT_W=3 instance rejects tap 3
        b_prev = div_b;
        if_b.sel_req_valid = 1'b1;
        if_b.sel_req       = 2'd3;
        adv();
        if_b.sel_req_valid = 1'b0;
        chk("b_err", {31'd0, if_b.sel_err}, 1);
        chk("b_ready", {31'd0, if_b.sel_req_ready}, 1);
        chk("b_busy", {31'd0, if_b.switch_busy}, 0);
        chk("b_done", {31'd0, if_b.switch_done}, 0);
        chk("b_cur_sel", {30'd0, if_b.cur_sel}, 0);
        chk("b_div_toggle", {31'd0, div_b}, {31'd0, ~b_prev});
        adv();
        chk("b_err_clr", {31'd0, if_b.sel_err}, 0);
        chk("b_div_toggle2", {31'd0, div_b}, {31'd0, b_prev});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
